// File: rtl/div_iter.sv
// Radix-2 restoring divider for the EX stage: one quotient bit per cycle,
// signed/unsigned, with a stall request while busy and a one-cycle ready pulse.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_div_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic             divzero_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             divzero_q, divzero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             accept;
    logic             last_step;
    logic             sign_a, sign_b;
    logic             trial_ge;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? -v : v;
    endfunction

    assign sign_a    = signed_div_i & opa_i[WIDTH-1];
    assign sign_b    = signed_div_i & opb_i[WIDTH-1];
    assign accept    = (state_q != BUSY) && start_i && !annul_i;
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // The partial remainder stays below the divisor, so the WIDTH-bit
    // difference is exact whenever the trial subtraction succeeds.
    assign shifted   = {acc_q, dvd_q[WIDTH-1]};
    assign trial_ge  = (shifted >= {1'b0, dvs_q});
    assign trial     = shifted[WIDTH-1:0] - dvs_q;

    assign stall_o   = rst_ni && ((state_q == BUSY) || accept);
    assign ready_o   = ready_q;
    assign divzero_o = divzero_q;
    assign quot_o    = quot_q;
    assign rem_o     = rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b0;
        divzero_d = divzero_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;

        if (annul_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            acc_d = trial_ge ? trial : shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], trial_ge};
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
                state_d   = DONE;
                ready_d   = 1'b1;
                divzero_d = 1'b0;
                quot_d    = cond_neg(dvd_d, qneg_q);
                rem_d     = cond_neg(acc_d, rneg_q);
                cnt_d     = '0;
            end
        end else if (start_i) begin
            dvd_d  = cond_neg(opa_i, sign_a);
            dvs_d  = cond_neg(opb_i, sign_b);
            acc_d  = '0;
            qneg_d = sign_a ^ sign_b;
            rneg_d = sign_a;
            cnt_d  = '0;
            if (opb_i == '0) begin
                state_d   = DONE;
                ready_d   = 1'b1;
                divzero_d = 1'b1;
                quot_d    = '1;
                rem_d     = opa_i;
            end else begin
                state_d = BUSY;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            divzero_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            divzero_q <= divzero_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
        end
    end

    // Working registers are fully reloaded on every accepted start.
    always_ff @(posedge clk_i) begin
        acc_q  <= acc_d;
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: WIDTH=32 and WIDTH=8 instances driven by
// scenario tasks, with expected results queued at issue and popped at ready.
module tb_div_iter;

    logic        clk;
    logic        rst_n;

    logic        start32, sd32, an32;
    logic [31:0] a32, b32;
    logic        stall32, ready32, dz32;
    logic [31:0] quot32, rem32;

    logic        start8, sd8, an8;
    logic [7:0]  a8, b8;
    logic        stall8, ready8, dz8;
    logic [7:0]  quot8, rem8;

    bit          sel;
    logic        cur_stall, cur_ready, cur_dz;
    logic [63:0] cur_quot, cur_rem;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_fail;

    div_iter #(.WIDTH(32)) u_div32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .signed_div_i(sd32),
        .annul_i(an32), .opa_i(a32), .opb_i(b32), .stall_o(stall32),
        .ready_o(ready32), .divzero_o(dz32), .quot_o(quot32), .rem_o(rem32)
    );

    div_iter #(.WIDTH(8)) u_div8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .signed_div_i(sd8),
        .annul_i(an8), .opa_i(a8), .opb_i(b8), .stall_o(stall8),
        .ready_o(ready8), .divzero_o(dz8), .quot_o(quot8), .rem_o(rem8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_stall = sel ? stall8 : stall32;
        cur_ready = sel ? ready8 : ready32;
        cur_dz    = sel ? dz8 : dz32;
        cur_quot  = sel ? {56'd0, quot8} : {32'd0, quot32};
        cur_rem   = sel ? {56'd0, rem8} : {32'd0, rem32};
    end

    function automatic int cur_w();
        return sel ? 8 : 32;
    endfunction

    // Reference built on native 64-bit signed division (truncates toward zero).
    function automatic void model(input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic s, input int w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic z);
        logic [63:0] m, a, b;
        longint      sa, sb_v;
        m = (64'd1 << w) - 64'd1;
        a = a_in & m;
        b = b_in & m;
        if (b == 64'd0) begin
            q = m;
            r = a;
            z = 1'b1;
            return;
        end
        sa   = (s && a[w-1]) ? (longint'(a) - (longint'(1) << w)) : longint'(a);
        sb_v = (s && b[w-1]) ? (longint'(b) - (longint'(1) << w)) : longint'(b);
        q = 64'(sa / sb_v) & m;
        r = 64'(sa % sb_v) & m;
        z = 1'b0;
    endfunction

    task automatic set_in(input bit st, input bit sd, input bit an,
                          input logic [63:0] a, input logic [63:0] b);
        if (sel) begin
            start8 = st; sd8 = sd; an8 = an; a8 = a[7:0]; b8 = b[7:0];
            start32 = 1'b0; an32 = 1'b0;
        end else begin
            start32 = st; sd32 = sd; an32 = an; a32 = a[31:0]; b32 = b[31:0];
            start8 = 1'b0; an8 = 1'b0;
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit s,
                         input logic [63:0] eq, input logic [63:0] er, input logic ez,
                         input bit now);
        exp_t e;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        set_in(1'b1, s, 1'b0, a, b);
        e.q = eq; e.r = er; e.z = ez;
        sb.push_back(e);
        #1;
        n_cmp++;
        if (cur_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_on_start: got %b want 1", cur_stall);
        end
    endtask

    task automatic collect(input string name, output int lat, output int stalls);
        exp_t e;
        bit   got;
        got = 0; lat = 0; stalls = 1;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
            @(negedge clk);
            if (cur_stall) stalls++;
            if (cur_ready) begin
                got = 1;
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL %s_unexpected_ready: got ready with empty queue", name);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (cur_quot !== e.q) begin
                        n_fail++;
                        $display("FAIL %s_quot: got %h want %h", name, cur_quot, e.q);
                    end
                    n_cmp++;
                    if (cur_rem !== e.r) begin
                        n_fail++;
                        $display("FAIL %s_rem: got %h want %h", name, cur_rem, e.r);
                    end
                    n_cmp++;
                    if (cur_dz !== e.z) begin
                        n_fail++;
                        $display("FAIL %s_divzero: got %b want %b", name, cur_dz, e.z);
                    end
                end
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: no ready after %0d cycles, want %0d", name, lat, cur_w() + 1);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_pulse_end(input string name);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (cur_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_width: got %b want 0", name, cur_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel = 0;
        start8 = 1'b0; sd8 = 1'b0; an8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b1; sd32 = 1'b0; an32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
        #3;
        n_cmp++;
        if (stall32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0", stall32);
        end
        #10;
        n_cmp++;
        if ({ready32, dz32, quot32, rem32} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b dz=%b q=%h r=%h want all 0",
                     ready32, dz32, quot32, rem32);
        end
        n_cmp++;
        if ({ready8, dz8, quot8, rem8} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs8: got rdy=%b dz=%b q=%h r=%h want all 0",
                     ready8, dz8, quot8, rem8);
        end
        start32 = 1'b0;
        #9;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, st;
        sel = 0;
        issue(100, 7, 0, 14, 2, 0, 0);
        collect("unsigned", lat, st);
        check_int("unsigned_latency", lat, 33);
        check_int("unsigned_stall_cycles", st, 33);
        check_pulse_end("unsigned");
        n_cmp++;
        if (cur_quot !== 64'd14) begin
            n_fail++;
            $display("FAIL unsigned_quot_hold: got %h want %h", cur_quot, 64'd14);
        end
    endtask

    task automatic test_signed();
        int lat, st;
        sel = 0;
        issue(64'hFFFF_FFF9, 2, 1, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 0, 0);
        collect("signed", lat, st);
        issue(64'h8000_0000, 64'hFFFF_FFFF, 1, 64'h8000_0000, 0, 0, 0);
        collect("overflow", lat, st);
        check_int("overflow_latency", lat, 33);
    endtask

    task automatic test_divzero();
        int lat, st;
        sel = 0;
        issue(5, 0, 1, 64'hFFFF_FFFF, 5, 1, 0);
        collect("divzero", lat, st);
        check_int("divzero_latency", lat, 1);
        check_int("divzero_stall_cycles", st, 1);
        check_pulse_end("divzero");
    endtask

    task automatic test_annul();
        int lat, st, nrdy, nstall;
        exp_t dropped;
        sel = 0;
        issue(100, 7, 0, 14, 2, 0, 0);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (9) @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        dropped = sb.pop_front();
        nrdy = 0; nstall = 0;
        repeat (40) begin
            @(negedge clk);
            if (cur_ready) nrdy++;
            if (cur_stall) nstall++;
        end
        check_int("annul_no_ready", nrdy, 0);
        check_int("annul_no_stall", nstall, 0);
        n_cmp++;
        if ({cur_quot, cur_rem, cur_dz} !== {64'hFFFF_FFFF, 64'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL annul_hold: got q=%h r=%h dz=%b want q=ffffffff r=5 dz=1",
                     cur_quot, cur_rem, cur_dz);
        end
        issue(9, 3, 0, 3, 0, 0, 0);
        collect("after_annul", lat, st);
    endtask

    task automatic test_back_to_back();
        int lat, st;
        logic [63:0] q, r;
        logic z;
        sel = 0;
        issue(100, 7, 0, 14, 2, 0, 0);
        collect("b2b_first", lat, st);
        issue(50, 5, 0, 10, 0, 0, 1);
        collect("b2b_second", lat, st);
        check_int("b2b_spacing", lat, 33);
        sel = 1;
        issue(64'hF9, 64'h02, 1, 64'hFD, 64'hFF, 0, 0);
        collect("w8_signed", lat, st);
        check_int("w8_latency", lat, 9);
        model(200, 9, 0, 8, q, r, z);
        issue(200, 9, 0, q, r, z, 1);
        collect("w8_b2b", lat, st);
        check_int("w8_b2b_spacing", lat, 9);
        check_pulse_end("w8_b2b");
    endtask

    task automatic test_random();
        int lat, st;
        logic [63:0] a, b, q, r;
        logic z;
        bit s;
        for (int k = 0; k < 2; k++) begin
            sel = (k == 1);
            for (int i = 0; i < 8; i++) begin
                a = {32'd0, $urandom};
                case (i % 4)
                    0:       b = {32'd0, $urandom};
                    1:       b = 64'($urandom_range(1, 20));
                    2:       b = 64'hFFFF_FFFF_FFFF_FFFD;
                    default: b = (i == 7) ? 64'd0 : 64'($urandom_range(1, 300));
                endcase
                s = $urandom_range(0, 1) == 1;
                model(a, b, s, cur_w(), q, r, z);
                issue(a, b, s, q, r, z, 0);
                collect("random", lat, st);
            end
        end
    endtask

    task automatic test_mid_reset();
        int nrdy;
        exp_t dropped;
        sel = 0;
        issue(1000, 3, 0, 333, 1, 0, 0);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (cur_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stall: got %b want 0", cur_stall);
        end
        #4;
        rst_n = 1'b1;
        dropped = sb.pop_front();
        nrdy = 0;
        repeat (40) begin
            @(negedge clk);
            if (cur_ready) nrdy++;
        end
        check_int("midreset_no_ready", nrdy, 0);
        n_cmp++;
        if ({cur_quot, cur_rem} !== 128'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got q=%h r=%h want 0", cur_quot, cur_rem);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_back_to_back();
        test_random();
        test_mid_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative (radix-2, one quotient bit per cycle) signed/unsigned integer divider for the EX stage of the MIPS pipeline. It replaces single-cycle division with a multi-cycle unit. While a division is in progress it drives a stall request to the hazard unit. On completion it delivers quotient (to LO) and remainder (to HI) for one cycle. The datapath width is a parameter, so the same block serves the 32-bit core and narrower test configurations.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a division; sampled only in IDLE or DONE.
- signed_div  in  1  1 = signed (div), 0 = unsigned (divu); sampled with start.
- annul  in  1  synchronous cancel (pipeline flush of EX); priority over start.
- opa  in  WIDTH  dividend; sampled with start.
- opb  in  WIDTH  divisor; sampled with start.
- stall  out  1  combinational: high when state is BUSY, or when start is accepted this cycle and annul is low.
- ready  out  1  registered: high for exactly one cycle when results are valid.
- divzero  out  1  registered: valid while ready; 1 = divisor was zero.
- quot  out  WIDTH  quotient (LO); holds its value until the next completion.
- rem  out  WIDTH  remainder (HI); holds its value until the next completion.

## Operation
- States:
  - IDLE: initial state.
  - BUSY: iterating; an internal counter runs 0..WIDTH-1.
  - DONE: ready=1.
- IDLE/DONE with start=1, annul=0:
  - Latch |opa| and |opb| (absolute values only when signed_div=1 and the operand MSB is 1).
  - Latch the quotient sign (sign_a XOR sign_b) and remainder sign (sign_a).
  - If opb==0, go to DONE directly. Otherwise go to BUSY with the counter cleared.
- IDLE/DONE with start=0, annul=0: DONE→IDLE; IDLE stays.
- BUSY, each edge: run one restoring step.
  - Shift {rem_acc, dividend} left by 1.
  - Trial-subtract the divisor with a WIDTH+1-bit compare.
  - Shift in the quotient bit.
  - On the WIDTH-th step, go to DONE. On that same edge, register the sign-corrected quot/rem (two's-complement negate when the latched sign is 1).
- start while BUSY is ignored.
- annul in any state: go to IDLE on the next edge. ready stays 0. quot/rem/divzero keep their previous values.
- Divide by zero: quot = all ones, rem = opa unmodified, divzero=1. The same rule applies for signed and unsigned.
- Signed overflow (most-negative / -1): quot = most-negative, rem = 0. This falls out of WIDTH-bit wrap of the magnitude path; no special case is needed.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Reset values: state IDLE, counter 0, ready 0, divzero 0, quot 0, rem 0; stall is 0 while in reset.

## Timing
- Start sampled at edge E0 (divisor nonzero): BUSY on edges E1..EWIDTH; ready=1 in the cycle after EWIDTH. Total latency from the start edge to valid results is WIDTH+1 cycles.
- Divisor zero: ready=1 in the cycle after E0, i.e. 1-cycle latency.
- stall is high from the cycle start is presented until the last BUSY cycle, inclusive. It is low in DONE, so the pipeline advances in the cycle ready is high.
- Back-to-back: start in the DONE cycle is accepted. ready drops on that edge and the next result follows WIDTH+1 cycles later.
- rst deassertion mid-operation: the block restarts in IDLE. No ready pulse is produced for the aborted operation.

## Test plan
- WIDTH=32, unsigned: opa=100, opb=7, start 1 cycle -> stall high for 33 cycles, then ready=1 for 1 cycle with quot=14, rem=2, divzero=0.
- Signed: opa=0xFFFFFFF9 (-7), opb=2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
- Signed overflow: opa=0x80000000, opb=0xFFFFFFFF -> quot=0x80000000, rem=0.
- Divide by zero: opa=5, opb=0 -> ready in the next cycle with quot=0xFFFFFFFF, rem=5, divzero=1; stall high only in the start cycle.
- annul asserted on BUSY cycle 10 of 100/7 -> IDLE on the next edge; no ready pulse; quot/rem keep prior values. A new start of 9/3 then yields quot=3, rem=0.
- Back-to-back: start 100/7, then start 50/5 in the DONE cycle -> two ready pulses 33 cycles apart with (14,2) then (10,0). Repeat at WIDTH=8 with opa=0xF9, opb=0x02 signed -> quot=0xFD, rem=0xFF.
